// File: rtl/uart_frame_loader.sv
// Serial image loader: UART bytes are packed into pixels and written linearly into the frame RAM.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the err_sum pulse.
module uart_frame_loader #(
    parameter int          CLK_FREQ  = 12000000,
    parameter int          BAUD      = 115200,
    parameter int          PIX_BITS  = 9,
    parameter int          IMG_W     = 160,
    parameter int          IMG_H     = 120,
    parameter int          ADDR_W    = 15,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                rx,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PIX_BITS-1:0] wr_data,
    output logic                busy,
    output logic                frame_done,
    output logic                err_frame,
    output logic                err_sum
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam int BPP   = (PIX_BITS <= 8) ? 1 : 2;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       rx_byte;
    logic             byte_valid;

    // Receiver: start bit re-checked at mid-bit, then every DIV cycles lands near each bit centre.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt  <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt    <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= shift_reg;
                            byte_valid <= 1'b1;
                        end else begin
                            err_frame <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    typedef enum logic [1:0] {
        HUNT,
        PIX,
        SUM,
        DONE
    } load_state_t;

    load_state_t         state;
    logic                byte_idx;
    logic [7:0]          low_byte;
    logic [PIX_BITS-1:0] pix_val;
    logic                pix_complete;
    logic                last_pix;

    // Little-endian assembly; casting to PIX_BITS drops any excess high bits.
    generate
        if (BPP == 1) begin : g_one_byte
            assign pix_val      = PIX_BITS'(rx_byte);
            assign pix_complete = 1'b1;
        end else begin : g_two_byte
            assign pix_val      = PIX_BITS'({rx_byte, low_byte});
            assign pix_complete = byte_idx;
        end
    endgenerate

    assign last_pix = (wr_addr == LAST_ADDR);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       sum_err_q;
    assign err_sum = sum_err_q;
`else
    assign err_sum = 1'b0;
`endif

    // wr_addr presents the written address during wr_en and advances the cycle after, never past the last pixel.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            byte_idx   <= 1'b0;
            low_byte   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
            sum_err_q  <= 1'b0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_err_q  <= 1'b0;
`endif
            if (wr_en && !last_pix) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            case (state)
                HUNT: begin
                    if (byte_valid && (rx_byte == SYNC_BYTE)) begin
                        state    <= PIX;
                        busy     <= 1'b1;
                        wr_addr  <= '0;
                        byte_idx <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                PIX: begin
                    if (err_frame) begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_byte;
`endif
                        if (pix_complete) begin
                            byte_idx <= 1'b0;
                            wr_en    <= 1'b1;
                            wr_data  <= pix_val;
                            if (last_pix) begin
`ifdef LOADER_CHECKSUM_EN
                                state      <= SUM;
`else
                                state      <= DONE;
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
`endif
                            end
                        end else begin
                            byte_idx <= 1'b1;
                            low_byte <= rx_byte;
                        end
                    end
                end
                SUM: begin
`ifdef LOADER_CHECKSUM_EN
                    if (err_frame) begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        busy <= 1'b0;
                        if (rx_byte == csum) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= HUNT;
                            sum_err_q <= 1'b1;
                        end
                    end
`else
                    state <= HUNT;
`endif
                end
                DONE: begin
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed bench for uart_frame_loader: small 4x2 images at 8 clocks per bit, 9-bit and 8-bit pixel instances.
module tb_uart_frame_loader;

    localparam int CLK_FREQ = 800;
    localparam int BAUD     = 100;
    localparam int DIV      = 8;
    localparam int AW       = 3;

    localparam logic [7:0] PIX_LO  [0:7] = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h23, 8'h55, 8'h00, 8'hFF};
    localparam logic [7:0] PIX_HI  [0:7] = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h01, 8'h7F};
    localparam logic [8:0] PIX_EXP [0:7] = '{9'h000, 9'h1FF, 9'h0A5, 9'h1A5, 9'h123, 9'h055, 9'h100, 9'h1FF};
    localparam logic [7:0] CSUM9 = 8'h09;
    localparam logic [7:0] B8    [0:7] = '{8'h01, 8'hA5, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    localparam logic [7:0] CSUM8 = 8'h58;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          rx;

    logic          wr_en, busy, frame_done, err_frame, err_sum;
    logic [AW-1:0] wr_addr;
    logic [8:0]    wr_data;

    logic          wr_en8, busy8, frame_done8, err_frame8, err_sum8;
    logic [AW-1:0] wr_addr8;
    logic [7:0]    wr_data8;

    int tests = 0;
    int fails = 0;
    int last_start = 0;

    uart_frame_loader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PIX_BITS(9), .IMG_W(4), .IMG_H(2),
        .ADDR_W(AW), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_in(clk_in), .reset(reset), .rx(rx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .err_frame(err_frame), .err_sum(err_sum)
    );

    uart_frame_loader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PIX_BITS(8), .IMG_W(4), .IMG_H(2),
        .ADDR_W(AW), .SYNC_BYTE(8'hA5)
    ) dut8 (
        .clk_in(clk_in), .reset(reset), .rx(rx),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .busy(busy8), .frame_done(frame_done8), .err_frame(err_frame8), .err_sum(err_sum8)
    );

    always #5 clk_in = ~clk_in;

    // Event monitor: logs every write and counts one-cycle pulses, sampled on the falling edge.
    int            cyc = 0;
    int            wr_cnt = 0, fd_cnt = 0, fd_cyc = 0, es_cnt = 0, es_cyc = 0, ef_cnt = 0, dbl_cnt = 0;
    int            wr8_cnt = 0, fd8_cnt = 0;
    logic          prev_wr = 1'b0;
    logic [AW-1:0] log_addr  [0:255];
    logic [8:0]    log_data  [0:255];
    logic [AW-1:0] log8_addr [0:255];
    logic [7:0]    log8_data [0:255];

    always @(negedge clk_in) begin
        cyc     <= cyc + 1;
        prev_wr <= wr_en;
        if (wr_en === 1'b1) begin
            log_addr[8'(wr_cnt)] <= wr_addr;
            log_data[8'(wr_cnt)] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (wr_en === 1'b1 && prev_wr === 1'b1) dbl_cnt <= dbl_cnt + 1;
        if (frame_done === 1'b1) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (err_sum === 1'b1) begin
            es_cnt <= es_cnt + 1;
            es_cyc <= cyc;
        end
        if (err_frame === 1'b1) ef_cnt <= ef_cnt + 1;
        if (wr_en8 === 1'b1) begin
            log8_addr[8'(wr8_cnt)] <= wr_addr8;
            log8_data[8'(wr8_cnt)] <= wr_data8;
            wr8_cnt <= wr8_cnt + 1;
        end
        if (frame_done8 === 1'b1) fd8_cnt <= fd8_cnt + 1;
    end

    task automatic send_bits(input logic [7:0] b, input logic stop_bit);
        @(negedge clk_in);
        last_start = cyc;
        rx = 1'b0;
        repeat (DIV) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk_in);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk_in);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b1);
    endtask

    task automatic send_frame9(input logic [7:0] csum_val);
        send_byte(8'hA5);
        for (int i = 0; i < 8; i++) begin
            send_byte(PIX_LO[i]);
            send_byte(PIX_HI[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_val);
`else
        if (csum_val == 8'h00) last_start = last_start;
`endif
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        tests++; if (wr_en !== 1'b0)      begin fails++; $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); end
        tests++; if (wr_addr !== '0)      begin fails++; $display("[TB] FAIL reset_wr_addr got %h want 0", wr_addr); end
        tests++; if (wr_data !== '0)      begin fails++; $display("[TB] FAIL reset_wr_data got %h want 0", wr_data); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
        tests++; if (err_frame !== 1'b0)  begin fails++; $display("[TB] FAIL reset_err_frame got %b want 0", err_frame); end
        tests++; if (err_sum !== 1'b0)    begin fails++; $display("[TB] FAIL reset_err_sum got %b want 0", err_sum); end
        tests++; if (busy8 !== 1'b0)      begin fails++; $display("[TB] FAIL reset_busy8 got %b want 0", busy8); end
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_noise_and_frame();
        int wc0, fd0, es0;
        do_reset();
        wc0 = wr_cnt; fd0 = fd_cnt; es0 = es_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        tests++; if (wr_cnt !== wc0) begin fails++; $display("[TB] FAIL noise_writes got %0d want 0", wr_cnt - wc0); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("[TB] FAIL noise_busy got %b want 0", busy); end
        send_byte(8'hA5);
        tests++; if (busy !== 1'b1)  begin fails++; $display("[TB] FAIL sync_busy got %b want 1", busy); end
        for (int i = 0; i < 8; i++) begin
            send_byte(PIX_LO[i]);
            send_byte(PIX_HI[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(CSUM9);
`endif
        tests++; if (wr_cnt - wc0 !== 8) begin fails++; $display("[TB] FAIL frame_write_count got %0d want 8", wr_cnt - wc0); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (log_addr[8'(wc0 + i)] !== AW'(i)) begin
                fails++; $display("[TB] FAIL frame_addr[%0d] got %0d want %0d", i, log_addr[8'(wc0 + i)], i);
            end
            tests++;
            if (log_data[8'(wc0 + i)] !== PIX_EXP[i]) begin
                fails++; $display("[TB] FAIL frame_data[%0d] got %h want %h", i, log_data[8'(wc0 + i)], PIX_EXP[i]);
            end
        end
        tests++; if (fd_cnt - fd0 !== 1) begin fails++; $display("[TB] FAIL frame_done_count got %0d want 1", fd_cnt - fd0); end
        tests++;
        if (fd_cyc - last_start < 76 || fd_cyc - last_start > 84) begin
            fails++; $display("[TB] FAIL frame_done_timing got %0d cycles after last start bit want 76..84", fd_cyc - last_start);
        end
        tests++; if (busy !== 1'b0)       begin fails++; $display("[TB] FAIL frame_end_busy got %b want 0", busy); end
        tests++; if (es_cnt !== es0)      begin fails++; $display("[TB] FAIL frame_err_sum got %0d want 0", es_cnt - es0); end
        tests++; if (dbl_cnt !== 0)       begin fails++; $display("[TB] FAIL wr_en_width got %0d long pulses want 0", dbl_cnt); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int wc0, fd0, es0;
        do_reset();
        wc0 = wr_cnt; fd0 = fd_cnt; es0 = es_cnt;
        send_frame9(CSUM9 ^ 8'h03);
        tests++; if (wr_cnt - wc0 !== 8) begin fails++; $display("[TB] FAIL badsum_writes got %0d want 8", wr_cnt - wc0); end
        tests++; if (es_cnt - es0 !== 1) begin fails++; $display("[TB] FAIL badsum_err_sum got %0d want 1", es_cnt - es0); end
        tests++; if (fd_cnt !== fd0)     begin fails++; $display("[TB] FAIL badsum_frame_done got %0d want 0", fd_cnt - fd0); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL badsum_busy got %b want 0", busy); end
        tests++;
        if (es_cyc - last_start < 76 || es_cyc - last_start > 84) begin
            fails++; $display("[TB] FAIL badsum_timing got %0d cycles want 76..84", es_cyc - last_start);
        end
    endtask
`endif

    task automatic test_frame_error();
        int wc0, fd0, ef0;
        do_reset();
        wc0 = wr_cnt; fd0 = fd_cnt; ef0 = ef_cnt;
        send_byte(8'hA5);
        send_byte(PIX_LO[0]); send_byte(PIX_HI[0]);
        send_byte(PIX_LO[1]); send_byte(PIX_HI[1]);
        send_byte(PIX_LO[2]);
        send_bits(PIX_HI[2], 1'b0);
        tests++; if (ef_cnt - ef0 !== 1) begin fails++; $display("[TB] FAIL ferr_pulse got %0d want 1", ef_cnt - ef0); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL ferr_busy got %b want 0", busy); end
        tests++; if (wr_cnt - wc0 !== 2) begin fails++; $display("[TB] FAIL ferr_writes got %0d want 2", wr_cnt - wc0); end
        send_byte(8'h12);
        tests++; if (wr_cnt - wc0 !== 2) begin fails++; $display("[TB] FAIL ferr_hunt_ignored got %0d want 2", wr_cnt - wc0); end
        send_frame9(CSUM9);
        tests++; if (wr_cnt - wc0 !== 10) begin fails++; $display("[TB] FAIL ferr_restart_writes got %0d want 10", wr_cnt - wc0); end
        tests++;
        if (log_addr[8'(wc0 + 2)] !== AW'(0)) begin
            fails++; $display("[TB] FAIL ferr_restart_addr got %0d want 0", log_addr[8'(wc0 + 2)]);
        end
        tests++;
        if (log_data[8'(wc0 + 9)] !== PIX_EXP[7]) begin
            fails++; $display("[TB] FAIL ferr_restart_last_data got %h want %h", log_data[8'(wc0 + 9)], PIX_EXP[7]);
        end
        tests++; if (fd_cnt - fd0 !== 1) begin fails++; $display("[TB] FAIL ferr_restart_done got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_pix8();
        int wc0, fd0;
        do_reset();
        wc0 = wr8_cnt; fd0 = fd8_cnt;
        send_byte(8'hA5);
        for (int i = 0; i < 8; i++) send_byte(B8[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(CSUM8);
`endif
        tests++; if (wr8_cnt - wc0 !== 8) begin fails++; $display("[TB] FAIL pix8_writes got %0d want 8", wr8_cnt - wc0); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (log8_addr[8'(wc0 + i)] !== AW'(i)) begin
                fails++; $display("[TB] FAIL pix8_addr[%0d] got %0d want %0d", i, log8_addr[8'(wc0 + i)], i);
            end
            tests++;
            if (log8_data[8'(wc0 + i)] !== B8[i]) begin
                fails++; $display("[TB] FAIL pix8_data[%0d] got %h want %h", i, log8_data[8'(wc0 + i)], B8[i]);
            end
        end
        tests++; if (fd8_cnt - fd0 !== 1) begin fails++; $display("[TB] FAIL pix8_done got %0d want 1", fd8_cnt - fd0); end
        tests++; if (busy8 !== 1'b0)      begin fails++; $display("[TB] FAIL pix8_busy got %b want 0", busy8); end
    endtask

    task automatic test_reset_midframe();
        int wc0;
        do_reset();
        wc0 = wr_cnt;
        send_byte(8'hA5);
        for (int i = 0; i < 3; i++) begin
            send_byte(PIX_LO[i]);
            send_byte(PIX_HI[i]);
        end
        tests++; if (busy !== 1'b1)      begin fails++; $display("[TB] FAIL mid_busy got %b want 1", busy); end
        tests++; if (wr_cnt - wc0 !== 3) begin fails++; $display("[TB] FAIL mid_writes got %0d want 3", wr_cnt - wc0); end
        @(negedge clk_in);
        rx = 1'b0;
        repeat (DIV) @(negedge clk_in);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        tests++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        tests++; if (wr_addr !== '0)   begin fails++; $display("[TB] FAIL midrst_wr_addr got %h want 0", wr_addr); end
        tests++; if (wr_data !== '0)   begin fails++; $display("[TB] FAIL midrst_wr_data got %h want 0", wr_data); end
        tests++; if (wr_en !== 1'b0)   begin fails++; $display("[TB] FAIL midrst_wr_en got %b want 0", wr_en); end
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        send_byte(8'h5A);
        send_byte(8'h5A);
        tests++; if (wr_cnt - wc0 !== 3) begin fails++; $display("[TB] FAIL midrst_hunt got %0d writes want 3", wr_cnt - wc0); end
        tests++; if (busy !== 1'b0)      begin fails++; $display("[TB] FAIL midrst_hunt_busy got %b want 0", busy); end
        send_frame9(CSUM9);
        tests++; if (wr_cnt - wc0 !== 11) begin fails++; $display("[TB] FAIL midrst_frame_writes got %0d want 11", wr_cnt - wc0); end
        tests++;
        if (log_addr[8'(wc0 + 3)] !== AW'(0)) begin
            fails++; $display("[TB] FAIL midrst_frame_addr got %0d want 0", log_addr[8'(wc0 + 3)]);
        end
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        test_reset();
        test_noise_and_frame();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_frame_error();
        test_pix8();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
